// File: rtl/pdm_pkg.sv
// Shared constants and saturation helper for the PDM modulator and CIC3 decimator.
// Widths here are the defaults; modules may override PCM_W and OSR_LOG2.
package pdm_pkg;

    localparam int PDM_PCM_W    = 16;
    localparam int PDM_OSR_LOG2 = 6;
    localparam int PDM_FS       = 1 << (PDM_PCM_W - 1);
    localparam int PDM_I1_W     = PDM_PCM_W + 4;
    localparam int PDM_I2_W     = PDM_PCM_W + 8;
    localparam int PDM_I1_MAX   = (1 << (PDM_I1_W - 1)) - 1;
    localparam int PDM_I2_MAX   = (1 << (PDM_I2_W - 1)) - 1;

    // Symmetric clamp to +/-(2^(w-1)-1); w must be below 32.
    function automatic logic signed [31:0] sat(
        input logic signed [31:0] v,
        input int                 w
    );
        logic signed [31:0] lim;
        lim = (32'sd1 <<< (w - 1)) - 32'sd1;
        if (v > lim) begin
            sat = lim;
        end else if (v < -lim) begin
            sat = -lim;
        end else begin
            sat = v;
        end
    endfunction

endpackage

// File: rtl/sdm2_core.sv
// Second-order CIFB sigma-delta modulator with saturating integrators.
// The output bit is registered and also serves as the feedback sign.
module sdm2_core
    import pdm_pkg::*;
#(
    parameter int PCM_W = PDM_PCM_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [PCM_W-1:0] x,
    output logic                    pdm_out
);

    localparam int I1_W = PCM_W + 4;
    localparam int I2_W = PCM_W + 8;
    localparam logic signed [31:0] FS = 32'sd1 <<< (PCM_W - 1);

    logic signed [I1_W-1:0] i1_q, i1_d;
    logic signed [I2_W-1:0] i2_q, i2_d;
    logic                   pdm_q, pdm_d;
    logic signed [31:0]     fb, s1, s2, i1_s, i2_s;

    always_comb begin
        fb    = pdm_q ? FS : -FS;
        s1    = 32'(i1_q) + 32'(x) - fb;
        // second stage integrates the pre-update i1
        s2    = 32'(i2_q) + 32'(i1_q) - fb;
        i1_s  = sat(s1, I1_W);
        i2_s  = sat(s2, I2_W);
        i1_d  = i1_s[I1_W-1:0];
        i2_d  = i2_s[I2_W-1:0];
        pdm_d = !i2_s[31];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            i1_q  <= '0;
            i2_q  <= '0;
            pdm_q <= 1'b0;
        end else begin
            i1_q  <= i1_d;
            i2_q  <= i2_d;
            pdm_q <= pdm_d;
        end
    end

    assign pdm_out = pdm_q;

endmodule

// File: rtl/pdm_modulator.sv
// PCM-to-PDM transmitter: one-entry sample buffer, linear interpolator
// over 2^OSR_LOG2 clocks, and a second-order sigma-delta core.
module pdm_modulator
    import pdm_pkg::*;
#(
    parameter int OSR_LOG2 = PDM_OSR_LOG2,
    parameter int PCM_W    = PDM_PCM_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [PCM_W-1:0] pcm_in,
    input  logic                    pcm_in_valid,
    output logic                    pcm_in_ready,
    output logic                    pdm_out,
    output logic                    frame_start,
    output logic                    underrun
);

    localparam int ACC_W  = PCM_W + OSR_LOG2 + 1;
    localparam int STEP_W = PCM_W + 1;

    logic [OSR_LOG2-1:0]     phase_q, phase_d;
    logic signed [PCM_W-1:0] buf_q, buf_d;
    logic signed [PCM_W-1:0] prev_q, prev_d;
    logic signed [PCM_W-1:0] tgt_q, tgt_d;
    logic                    buf_full_q, buf_full_d;
    logic                    underrun_q, underrun_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [STEP_W-1:0] step_q, step_d;
    logic                    frame_end, accept;
    logic signed [PCM_W-1:0] x;

    assign frame_end    = &phase_q;
    assign accept       = pcm_in_valid && !buf_full_q;
    assign pcm_in_ready = !buf_full_q;
    assign frame_start  = !rst && (phase_q == '0);
    assign underrun     = underrun_q;
    assign x            = acc_q[OSR_LOG2 +: PCM_W];

    always_comb begin
        phase_d    = phase_q + OSR_LOG2'(1);
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        prev_d     = prev_q;
        tgt_d      = tgt_q;
        underrun_d = underrun_q;
        acc_d      = acc_q + ACC_W'(step_q);
        step_d     = step_q;
        if (accept) begin
            buf_d      = pcm_in;
            buf_full_d = 1'b1;
        end
        if (frame_end) begin
            prev_d = tgt_q;
            if (buf_full_q) begin
                tgt_d      = buf_q;
                buf_full_d = 1'b0;
            end else begin
                underrun_d = 1'b1;
            end
            // exact reload each frame so the ramp never drifts
            acc_d  = ACC_W'(tgt_q) <<< OSR_LOG2;
            step_d = STEP_W'(tgt_d) - STEP_W'(tgt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q    <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            prev_q     <= '0;
            tgt_q      <= '0;
            underrun_q <= 1'b0;
            acc_q      <= '0;
            step_q     <= '0;
        end else begin
            phase_q    <= phase_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            prev_q     <= prev_d;
            tgt_q      <= tgt_d;
            underrun_q <= underrun_d;
            acc_q      <= acc_d;
            step_q     <= step_d;
        end
    end

    sdm2_core #(
        .PCM_W(PCM_W)
    ) u_sdm (
        .clk    (clk),
        .rst    (rst),
        .x      (x),
        .pdm_out(pdm_out)
    );

endmodule
